// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: produces the next partial
// remainder and quotient from the current ones.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH+1:0] trial_s;

  // Shift {rem,quo} left by one and attempt to subtract the divisor.
  always_comb begin
    rem_sh_s = {rem, quo[WIDTH-1]};
    trial_s  = {1'b0, rem_sh_s} - {2'b00, dvs};
    if (!trial_s[WIDTH+1]) begin
      rem_n = trial_s[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh_s[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: magnitude division over WIDTH
// clocks, then a sign/zero-divisor fix-up cycle and a one-cycle done pulse.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             sign_q_r, sign_r_r, zero_r;

  logic [WIDTH-1:0] rem_s, quo_s;
  logic [WIDTH-1:0] abs_dd_s, abs_dv_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_r),
    .quo   (quo_r),
    .dvs   (dvs_r),
    .rem_n (rem_s),
    .quo_n (quo_s)
  );

  // Operand magnitudes; only signed operations fold negative inputs.
  always_comb begin
    if (is_signed && dividend[WIDTH-1]) begin
      abs_dd_s = -dividend;
    end else begin
      abs_dd_s = dividend;
    end
    if (is_signed && divisor[WIDTH-1]) begin
      abs_dv_s = -divisor;
    end else begin
      abs_dv_s = divisor;
    end
  end

  // Result fix-up: restore signs, or force the zero-divisor convention.
  always_comb begin
    if (sign_r_r) begin
      r_fix_s = -rem_r;
    end else begin
      r_fix_s = rem_r;
    end
    if (zero_r) begin
      q_fix_s = ALL_ONES;
    end else if (sign_q_r) begin
      q_fix_s = -quo_r;
    end else begin
      q_fix_s = quo_r;
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      zero_r      <= 1'b0;
      q           <= {WIDTH{1'b0}};
      r           <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= CALC;
            busy     <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= abs_dd_s;
            dvs_r    <= abs_dv_s;
            sign_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_r <= is_signed & dividend[WIDTH-1];
            zero_r   <= (divisor == {WIDTH{1'b0}});
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_s;
          quo_r <= quo_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          q           <= q_fix_s;
          r           <= r_fix_s;
          div_by_zero <= zero_r;
          busy        <= 1'b0;
          done        <= 1'b1;
          state_r     <= DONE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vectors, randomized ops
// against an arithmetic reference, busy guard, reset abort, back-to-back.
module tb_iter_divider;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] q, r;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  iter_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain language arithmetic with the architectural corner rules.
  task automatic ref_div(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                         output logic [31:0] eq, output logic [31:0] er, output logic ez);
    int a, b;
    a = dd;
    b = dv;
    ez = (dv == 32'd0);
    if (ez) begin
      eq = 32'hFFFF_FFFF;
      er = dd;
    end else if (!sg) begin
      eq = dd / dv;
      er = dd % dv;
    end else if (a == 32'sh8000_0000 && b == -1) begin
      eq = 32'h8000_0000;
      er = 32'd0;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait for done.
  task automatic do_op(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                       output int lat, output int busy_cyc, output logic [31:0] mid_q);
    @(negedge clk);
    dividend = dd; divisor = dv; is_signed = sg; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    mid_q = 32'd0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) mid_q = q;
      if (done) break;
      if (busy) busy_cyc++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({q, r, busy, done, div_by_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
               q, r, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] t_dd [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                              32'h8000_0000, 32'h8000_0000, 32'h1234, 32'd9, 32'd81};
    logic [31:0] t_dv [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd2,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd9};
    logic        t_sg [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_q  [9] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFC,
                              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd9};
    logic [31:0] t_r  [9] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1,
                              32'd0, 32'h8000_0000, 32'h1234, 32'd0, 32'd0};
    logic        t_z  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] prev_q;
    logic [31:0] mid_q;
    int lat, bc;
    prev_q = q;
    for (int i = 0; i < 9; i++) begin
      do_op(t_dd[i], t_dv[i], t_sg[i], lat, bc, mid_q);
      n_checks++;
      if (q !== t_q[i] || r !== t_r[i] || div_by_zero !== t_z[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]: got q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, q, r, div_by_zero, t_q[i], t_r[i], t_z[i]);
      end
      n_checks++;
      if (lat != LAT || bc != LAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy=%0d, required %0d/%0d",
                 i, lat, bc, LAT, LAT);
      end
      n_checks++;
      if (mid_q !== prev_q) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: mid-op q=%h, required %h", i, mid_q, prev_q);
      end
      prev_q = t_q[i];
    end
  endtask

  task automatic test_random;
    logic [31:0] dd, dv, eq, er, mid_q;
    logic        sg, ez;
    int lat, bc;
    for (int i = 0; i < 24; i++) begin
      dd = $urandom;
      case ($urandom_range(0, 4))
        0: dv = 32'd0;
        1: dv = 32'($urandom_range(1, 15));
        2: dv = -32'($urandom_range(1, 15));
        default: dv = $urandom >> $urandom_range(0, 31);
      endcase
      sg = 1'($urandom_range(0, 1));
      ref_div(dd, dv, sg, eq, er, ez);
      do_op(dd, dv, sg, lat, bc, mid_q);
      n_checks++;
      if (q !== eq || r !== er || div_by_zero !== ez || lat != LAT) begin
        n_fail++;
        $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h dbz=%b lat=%0d, required q=%h r=%h dbz=%b lat=%0d",
                 i, dd, dv, sg, q, r, div_by_zero, lat, eq, er, ez, LAT);
      end
    end
  endtask

  task automatic test_busy_guard;
    int lat;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (!done || lat != LAT || q !== 32'd14 || r !== 32'd2) begin
      n_fail++;
      $display("FAIL busy_guard: got done=%b lat=%0d q=%0d r=%0d, required done=1 lat=%0d q=14 r=2",
               done, lat, q, r, LAT);
    end
  endtask

  task automatic test_reset_abort;
    int seen_done;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got busy=%b q=%h r=%h, required 0/0/0", busy, q, r);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", seen_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mid_q;
    int lat, bc;
    do_op(32'd100, 32'd7, 1'b0, lat, bc, mid_q);
    n_checks++;
    if (!done || q !== 32'd14 || lat != LAT) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b q=%0d lat=%0d, required 1/14/%0d", done, q, lat, LAT);
    end
    do_op(32'd81, 32'd9, 1'b0, lat, bc, mid_q);
    n_checks++;
    if (q !== 32'd9 || r !== 32'd0 || lat != LAT || mid_q !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d mid_q=%0d, required 9/0/%0d/14",
               q, r, lat, mid_q, LAT);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b one cycle later, required 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_guard();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
